// File: rtl/mx6_arb.sv
// mx6_arb: round-robin arbiter that shares one 6:1 selector among six requesters.
// It issues a one-hot grant and drives sel_2..sel_0 with the binary index of the
// owner. A hold-time limit (MAX_HOLD) keeps access fair, and a per-owner lock
// exempts the current owner from that limit.
module mx6_arb #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic       sys_clk,
    input  logic       reset,
    input  logic [5:0] req,
    input  logic [5:0] lock,
    output logic [5:0] gnt,
    output logic       sel_0,
    output logic       sel_1,
    output logic       sel_2,
    output logic       busy
);

    localparam int unsigned N_REQ = 6;
    localparam int unsigned IDX_W = 3;
    localparam int unsigned CNT_W = 8;

    // Saturation point of the hold counter. With no limit it simply parks at all-ones.
    localparam logic [CNT_W-1:0] HOLD_LAST = (MAX_HOLD == 0) ? {CNT_W{1'b1}}
                                                             : CNT_W'(MAX_HOLD - 1);
    localparam bit HOLD_EN = (MAX_HOLD != 0);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [N_REQ-1:0]   gnt_d;
    logic [IDX_W-1:0]   sel_q, sel_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_d;

    logic               win_found;
    logic [IDX_W-1:0]   win_idx;
    logic [IDX_W-1:0]   cand;

    logic               own_req;
    logic               own_lock;
    logic               others_wait;
    logic               at_limit;
    logic               timeout;
    logic               release_own;

    // Circular search for the next requester, starting just after the last owner.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= int'(N_REQ); k++) begin
            cand = IDX_W'((int'(ptr_q) + k) % int'(N_REQ));
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Release conditions for the current owner (its index is held in sel_q).
    always_comb begin
        own_req     = req[sel_q];
        own_lock    = lock[sel_q];
        others_wait = |(req & ~gnt);
        at_limit    = HOLD_EN && (cnt_q == HOLD_LAST);
        timeout     = at_limit && !own_lock && others_wait;
        release_own = !own_req || timeout;
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;

        case (state_q)
            S_IDLE: begin
                // With no requester, sel keeps its last value so q stays steady.
                if (win_found) begin
                    gnt_d   = N_REQ'(1) << win_idx;
                    sel_d   = win_idx;
                    cnt_d   = '0;
                    state_d = S_GRANT;
                end
            end
            S_GRANT: begin
                if (release_own) begin
                    // sel is held through the turnaround cycle.
                    gnt_d   = '0;
                    ptr_d   = sel_q;
                    state_d = S_IDLE;
                end else if (cnt_q != HOLD_LAST) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                gnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase

        busy_d = |gnt_d;
    end

    // State and output registers; reset clears the grant and selector immediately.
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            gnt     <= '0;
            sel_q   <= '0;
            ptr_q   <= IDX_W'(N_REQ - 1);
            cnt_q   <= '0;
            busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt     <= gnt_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            busy    <= busy_d;
        end
    end

    assign sel_0 = sel_q[0];
    assign sel_1 = sel_q[1];
    assign sel_2 = sel_q[2];

endmodule

// File: tb/tb_mx6_arb.sv
// tb_mx6_arb: scoreboard bench for mx6_arb. The stimulus process drives req/lock
// on the falling edge and queues the hand-computed grant/selector expected after
// the next rising edge; a monitor pops and compares shortly after each rising edge.
module tb_mx6_arb;

    logic       sys_clk;
    logic       reset;
    logic [5:0] req;
    logic [5:0] lock;
    logic [5:0] gnt;
    logic       sel_0;
    logic       sel_1;
    logic       sel_2;
    logic       busy;

    int checks = 0;
    int errors = 0;

    logic [9:0] exp_q[$];
    string      name_q[$];

    mx6_arb #(.MAX_HOLD(8)) dut (
        .sys_clk (sys_clk),
        .reset   (reset),
        .req     (req),
        .lock    (lock),
        .gnt     (gnt),
        .sel_0   (sel_0),
        .sel_1   (sel_1),
        .sel_2   (sel_2),
        .busy    (busy)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Compare packed {gnt, sel, busy} against the expected value.
    task automatic check(input string nm, input logic [9:0] act, input logic [9:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got gnt=%b sel=%b busy=%b, expected gnt=%b sel=%b busy=%b",
                     nm, act[9:4], act[3:1], act[0], exp[9:4], exp[3:1], exp[0]);
        end
    endtask

    // Drive one cycle of inputs and queue the output expected after the next rising edge.
    task automatic step(input logic [5:0] r, input logic [5:0] l,
                        input logic [5:0] eg, input logic [2:0] es, input string nm);
        @(negedge sys_clk);
        req  = r;
        lock = l;
        exp_q.push_back({eg, es, (eg != 6'd0)});
        name_q.push_back(nm);
    endtask

    // Assert reset between clock edges and check that outputs clear without an edge.
    task automatic do_reset(input string nm);
        @(negedge sys_clk);
        req   = '0;
        lock  = '0;
        reset = 1'b1;
        #1;
        check(nm, {gnt, sel_2, sel_1, sel_0, busy}, 10'd0);
        #1;
        reset = 1'b0;
    endtask

    // Monitor: pop and compare one expectation per rising edge.
    initial begin
        logic [9:0] e;
        string      nm;
        forever begin
            @(posedge sys_clk);
            #1;
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                check(nm, {gnt, sel_2, sel_1, sel_0, busy}, e);
            end
        end
    end

    // Watchdog.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got running, expected done");
        $fatal(1, "watchdog expired");
    end

    // Directed stimulus.
    initial begin
        reset = 1'b1;
        req   = '0;
        lock  = '0;
        #2;
        check("reset_init", {gnt, sel_2, sel_1, sel_0, busy}, 10'd0);
        @(negedge sys_clk);
        reset = 1'b0;

        // 1: single request, then drop.
        step(6'b000001, 6'b0, 6'b000001, 3'd0, "t1_grant");
        step(6'b000000, 6'b0, 6'b000000, 3'd0, "t1_release");

        // 2: all requesting, hold limit rotates owners 0..5,0 with one idle gap.
        do_reset("t2_reset");
        for (int n = 0; n < 7; n++) begin
            for (int c = 0; c < 8; c++)
                step(6'h3F, 6'b0, 6'b000001 << (n % 6), 3'(n % 6), "t2_owner");
            step(6'h3F, 6'b0, 6'b000000, 3'(n % 6), "t2_gap");
        end
        step(6'b000000, 6'b0, 6'b000000, 3'd0, "t2_idle");

        // 3: locked owner 4 keeps grant past the limit; unlock releases to 5.
        do_reset("t3_reset");
        for (int c = 0; c < 20; c++)
            step(6'b110000, 6'b010000, 6'b010000, 3'd4, "t3_locked");
        step(6'b110000, 6'b000000, 6'b000000, 3'd4, "t3_unlock_rel");
        step(6'b110000, 6'b000000, 6'b100000, 3'd5, "t3_next5");
        step(6'b000000, 6'b000000, 6'b000000, 3'd5, "t3_drop");

        // 4: sole requester keeps grant; a new request forces release.
        for (int c = 0; c < 30; c++)
            step(6'b000100, 6'b0, 6'b000100, 3'd2, "t4_sole");
        step(6'b001100, 6'b0, 6'b000000, 3'd2, "t4_release");
        step(6'b001100, 6'b0, 6'b001000, 3'd3, "t4_next3");
        step(6'b000000, 6'b0, 6'b000000, 3'd3, "t4_drop");

        // 5: async reset mid-grant, then index 0 wins first.
        for (int c = 0; c < 3; c++)
            step(6'b100000, 6'b0, 6'b100000, 3'd5, "t5_owner5");
        do_reset("t5_async_reset");
        step(6'b100001, 6'b0, 6'b000001, 3'd0, "t5_first0");
        step(6'b000000, 6'b0, 6'b000000, 3'd0, "t5_drop");

        // 6: owner 1 drops on its timeout edge; pointer moves so 5 beats 0.
        for (int c = 0; c < 8; c++)
            step(6'b000010, 6'b0, 6'b000010, 3'd1, "t6_owner1");
        step(6'b000000, 6'b0, 6'b000000, 3'd1, "t6_release");
        step(6'b100001, 6'b0, 6'b100000, 3'd5, "t6_five_first");
        step(6'b000001, 6'b0, 6'b000000, 3'd5, "t6_rel5");
        step(6'b000001, 6'b0, 6'b000001, 3'd0, "t6_then0");
        step(6'b000000, 6'b0, 6'b000000, 3'd0, "t6_end");

        // 7: lock on a non-owner does not stop the owner's timeout.
        for (int c = 0; c < 8; c++)
            step(6'b000110, 6'b000100, 6'b000010, 3'd1, "t7_owner1");
        step(6'b000110, 6'b000100, 6'b000000, 3'd1, "t7_timeout");
        step(6'b000100, 6'b000000, 6'b000100, 3'd2, "t7_next2");
        step(6'b000000, 6'b000000, 6'b000000, 3'd2, "t7_drop");

        repeat (3) @(negedge sys_clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
